rr_arbiter16: RTL and testbench
===============================

// Module: rr_arbiter16
// PURPOSE
//   Round-robin arbiter sharing one downstream resource among N requesters.
//   Built on the 16-way priority-encoding function, with a rotating priority pointer
//   for fairness and a grant-hold/release handshake.
//   A hold limit stops one requester from monopolising the resource.
//   Sits between request sources and the shared datapath. Drives one-hot grant plus an encoded grant index.
// PARAMETERS
//   N         16  number of requesters
//   IDW        4  width of grant_id; must satisfy 2**IDW >= N
//   MAX_HOLD   8  max cycles one grant may be held; 0 = unlimited
// PORTS
//   clk          in   1    clock, rising edge
//   rst_n        in   1    asynchronous active-low reset
//   en           in   1    arbitration enable; gates new grants only
//   req          in   N    request vector; bit i = requester i
//   done         in   1    current holder releases the resource (1-cycle pulse)
//   grant        out  N    one-hot grant; all-zero when no grant
//   grant_id     out  IDW  binary index of granted requester; 0 when no grant
//   grant_valid  out  1    a grant is active (== |grant)
//   forced       out  1    1-cycle pulse: grant revoked by hold limit
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - grant=0, grant_id=0, grant_valid=0, forced=0.
//     - ptr=0, hold_cnt=0, state=IDLE.
//   State IDLE:
//     - If en=1 and |req: winner = first set req bit at index >= ptr, searching upward and wrapping N-1 -> 0.
//     - Winner registered at the next edge: state=GRANT, grant/grant_id/grant_valid set, hold_cnt=0.
//     - Latency req -> grant = 1 cycle.
//     - Otherwise remain in IDLE with all outputs 0.
//   State GRANT:
//     - Release condition: done=1, OR req[grant_id]=0, OR (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
//     - On release, at the next edge:
//       - grant=0, grant_valid=0, grant_id=0, state=IDLE.
//       - ptr = (grant_id+1) mod N, so winner 15 -> ptr 0.
//     - forced pulses on that same edge only when the hold limit alone caused release (done=0, req still high).
//     - Otherwise hold_cnt increments; the grant is unchanged.
//   Timing and gaps:
//     - A grant lasts >= 1 cycle.
//     - There is always exactly 1 idle cycle between consecutive grants; no back-to-back grants.
//   Input rules:
//     - en=0 during GRANT does not abort the current grant; it only blocks the next arbitration.
//     - done while grant_valid=0 is ignored.
//     - req changes on non-granted bits during GRANT are ignored until the next IDLE.
//     - Exactly one grant bit is ever set; grant_id always encodes it.
//   Reset mid-grant clears outputs immediately (asynchronously) and restores ptr=0.
//   Widths:
//     - hold_cnt is wide enough for MAX_HOLD-1.
//     - ptr is IDW bits with modulo-N wrap; for non-power-of-2 N, wrap is explicit.
// TESTING
//   1 Reset: rst_n=0 with req=16'hFFFF -> all outputs 0.
//     After release, first grant is grant_id=0 one cycle after en=1.
//   2 Single requester: req=16'h0010, done pulsed 3 cycles after grant ->
//     grant=16'h0010 / grant_id=4 for 3 cycles, then 0; next grant after 1 idle cycle; forced=0.
//   3 Wrap fairness: req=16'h8001 held, done pulsed every grant ->
//     grant_id sequence 0,15,0,15 with 1-cycle gaps.
//   4 Hold limit: req=16'hFFFF, done=0, MAX_HOLD=8 ->
//     each grant exactly 8 cycles, grant_id 0,1,2,...,15,0; forced pulses at each release.
//   5 Enable: en=0 with req=16'h0004 -> no grant.
//     en dropped mid-grant -> grant persists until done; no new grant while en=0.
//   6 Requester drop + reset: req[grant_id] cleared mid-grant -> release next edge, forced=0.
//     rst_n pulsed mid-grant -> grant=0 immediately, next winner searched from ptr=0.

Source files
------------

// File: rtl/rr_arbiter16.sv
// Round-robin arbiter: rotating-priority winner search, grant held until done,
// requester drop, or the hold limit revokes it.
//
// state | meaning
// IDLE  | no grant; arbitrate among req when en=1
// GRANT | one requester owns the resource until release
module rr_arbiter16 #(
  parameter int N        = 16,
  parameter int IDW      = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           en,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           forced
);

  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [0:0]     IDLE    = 1'b0;
  localparam logic [0:0]     GRANT   = 1'b1;
  localparam logic [IDW-1:0] LAST_ID = IDW'(N - 1);
  localparam logic [HCW-1:0] HOLD_TC = HCW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hold_cnt;
  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] idx;
  logic           hold_hit;
  logic           release_now;

  // First set request at or above ptr, wrapping past N-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = IDW'((int'(ptr) + i) % N);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign hold_hit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_TC);
  assign release_now = done || !req[grant_id] || hold_hit;
  assign grant_valid = |grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      grant_id <= '0;
      forced   <= 1'b0;
    end else begin
      forced <= 1'b0;
      case (state)
        IDLE: begin
          if (en && win_found) begin
            state    <= GRANT;
            grant    <= {{(N-1){1'b0}}, 1'b1} << win_id;
            grant_id <= win_id;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            grant    <= '0;
            grant_id <= '0;
            hold_cnt <= '0;
            ptr      <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            // Only a revocation by the limit counts as forced.
            forced   <= hold_hit && !done && req[grant_id];
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter16.sv
// Bench for rr_arbiter16: cycle-level reference model compared every cycle,
// plus directed scenarios with hand-computed grant sequences.
module tb_rr_arbiter16;
  localparam int N        = 16;
  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = 16'h0000;
  logic        done = 1'b0;
  logic [15:0] grant;
  logic [3:0]  grant_id;
  logic        grant_valid;
  logic        forced;

  int total = 0;
  int bad   = 0;

  rr_arbiter16 #(.N(N), .IDW(4), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
    .grant(grant), .grant_id(grant_id), .grant_valid(grant_valid), .forced(forced)
  );

  always #5 clk = ~clk;

  // Reference model: holder index (-1 = none), cycles held so far, next search start.
  int m_holder = -1;
  int m_ptr    = 0;
  int m_held   = 0;
  bit m_forced = 1'b0;

  function automatic bit req_bit(input logic [15:0] r, input int i);
    logic [31:0] v;
    v = 32'(i);
    return r[v[3:0]];
  endfunction

  function automatic int pick(input logic [15:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (req_bit(r, (p + k) % N)) return (p + k) % N;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_holder <= -1;
      m_ptr    <= 0;
      m_held   <= 0;
      m_forced <= 1'b0;
    end else begin
      m_forced <= 1'b0;
      if (m_holder < 0) begin
        if (en && req != 16'h0000) begin
          m_holder <= pick(req, m_ptr);
          m_held   <= 1;
        end
      end else if (done || !req_bit(req, m_holder) || (MAX_HOLD != 0 && m_held == MAX_HOLD)) begin
        m_forced <= !done && req_bit(req, m_holder);
        m_holder <= -1;
        m_ptr    <= (m_holder + 1) % N;
      end else begin
        m_held <= m_held + 1;
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] eg;
    logic [31:0] hv;
    logic [3:0]  eid;
    hv  = 32'(m_holder);
    eg  = (m_holder < 0) ? 16'h0000 : (16'h0001 << hv[3:0]);
    eid = (m_holder < 0) ? 4'd0 : hv[3:0];
    total++;
    if (grant !== eg || grant_id !== eid || grant_valid !== (m_holder >= 0) || forced !== m_forced) begin
      bad++;
      $display("FAIL model t=%0t: grant=%h id=%0d valid=%b forced=%b, expected grant=%h id=%0d valid=%b forced=%b",
               $time, grant, grant_id, grant_valid, forced, eg, eid, (m_holder >= 0), m_forced);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string nm, input bit ev, input int eid, input bit ef);
    logic [15:0] eg;
    logic [31:0] iv;
    iv = 32'(eid);
    eg = ev ? (16'h0001 << iv[3:0]) : 16'h0000;
    total++;
    if (grant !== eg || grant_id !== iv[3:0] || grant_valid !== ev || forced !== ef) begin
      bad++;
      $display("FAIL %s: grant=%h id=%0d valid=%b forced=%b, expected grant=%h id=%0d valid=%b forced=%b",
               nm, grant, grant_id, grant_valid, forced, eg, iv[3:0], ev, ef);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
    $fatal(1);
  end

  initial begin
    // 1: reset holds everything at zero even with all requests and en high
    en = 1'b1; req = 16'hFFFF;
    repeat (3) cyc();
    chk("reset_outputs", 0, 0, 0);
    rst_n = 1'b1;
    cyc(); chk("first_grant", 1, 0, 0);
    req = 16'h0000;
    cyc(); chk("drop_release", 0, 0, 0);

    // 2: single requester, done after 3 grant cycles (ptr=1)
    req = 16'h0010;
    cyc(); chk("single_c1", 1, 4, 0);
    cyc(); chk("single_c2", 1, 4, 0);
    cyc(); chk("single_c3", 1, 4, 0);
    done = 1'b1;
    cyc(); chk("single_rel", 0, 0, 0);
    done = 1'b0;
    cyc(); chk("single_regrant", 1, 4, 0);
    req = 16'h0000;
    cyc(); chk("single_end", 0, 0, 0);

    // 3: wrap fairness from ptr=0 after a reset pulse
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1; req = 16'h8001; done = 1'b1;
    cyc(); chk("wrap_g0", 1, 0, 0);
    cyc(); chk("wrap_gap0", 0, 0, 0);
    cyc(); chk("wrap_g15", 1, 15, 0);
    cyc(); chk("wrap_gap1", 0, 0, 0);
    cyc(); chk("wrap_g0b", 1, 0, 0);
    cyc(); chk("wrap_gap2", 0, 0, 0);
    cyc(); chk("wrap_g15b", 1, 15, 0);
    done = 1'b0; req = 16'h0000;
    cyc(); chk("wrap_end", 0, 0, 0);

    // 4: hold limit, every requester active, ptr=0
    req = 16'hFFFF;
    for (int g = 0; g <= 16; g++) begin
      cyc(); chk("hold_grant", 1, g % 16, 0);
      for (int c = 1; c < MAX_HOLD; c++) begin
        cyc(); chk("hold_keep", 1, g % 16, 0);
      end
      cyc(); chk("hold_forced", 0, 0, 1);
    end
    req = 16'h0000;
    cyc(); chk("hold_end", 0, 0, 0);

    // 5: enable gating (ptr=1)
    en = 1'b0; req = 16'h0004;
    repeat (3) begin
      cyc(); chk("en_off_idle", 0, 0, 0);
    end
    en = 1'b1;
    cyc(); chk("en_grant", 1, 2, 0);
    en = 1'b0;
    cyc(); chk("en_drop_keep1", 1, 2, 0);
    cyc(); chk("en_drop_keep2", 1, 2, 0);
    done = 1'b1;
    cyc(); chk("en_done_rel", 0, 0, 0);
    done = 1'b0;
    repeat (3) begin
      cyc(); chk("en_off_nogrant", 0, 0, 0);
    end
    req = 16'h0000; en = 1'b1;
    cyc(); chk("en_end", 0, 0, 0);

    // 6: requester drop then reset mid-grant (ptr=3)
    req = 16'h0030;
    cyc(); chk("drop_g4", 1, 4, 0);
    cyc(); chk("drop_keep", 1, 4, 0);
    req = 16'h0020;
    cyc(); chk("drop_rel", 0, 0, 0);
    cyc(); chk("drop_g5", 1, 5, 0);
    rst_n = 1'b0;
    #1; chk("async_clear", 0, 0, 0);
    cyc(); chk("rst_hold", 0, 0, 0);
    rst_n = 1'b1; req = 16'h0041;
    cyc(); chk("rst_ptr0", 1, 0, 0);
    req = 16'h0000;
    cyc(); chk("final_idle", 0, 0, 0);

    repeat (2) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
